// File: rtl/afe_spi_shifter.sv
// Write-only SPI master for the AFE attenuator/switch chains: one command word in, N bits out MSB-first, then an LE pulse.
// Optional build macro AFE_SPI_BROADCAST_EN makes lane code 7 drive every lane at once.
module afe_spi_shifter #(
    parameter int CLK_RATE        = 99999001,
    parameter int SPI_RATE        = 1000000,
    parameter int CHANNEL_COUNT   = 2,
    parameter int DATA_WIDTH      = 24,
    parameter int LE_HALF_PERIODS = 2
) (
    input  logic                     sysClk,
    input  logic                     sysReset,
    input  logic                     sysCsrStrobe,
    input  logic [31:0]              sysGPIO_OUT,
    output logic [31:0]              status,
    output logic [CHANNEL_COUNT-1:0] AFE_SPI_CLK,
    output logic [CHANNEL_COUNT-1:0] AFE_SPI_SDI,
    output logic [CHANNEL_COUNT-1:0] AFE_SPI_LE
);

`ifdef AFE_SPI_BROADCAST_EN
    localparam bit BROADCAST = 1'b1;
`else
    localparam bit BROADCAST = 1'b0;
`endif

    localparam int D         = CLK_RATE / (2 * SPI_RATE);
    localparam int LATCH_LEN = LE_HALF_PERIODS * D;
    localparam int TW        = $clog2(LATCH_LEN);
    localparam logic [TW-1:0] PHASE_RELOAD = TW'(D - 1);
    localparam logic [TW-1:0] LATCH_RELOAD = TW'(LATCH_LEN - 1);

    typedef enum logic [2:0] {IDLE, SHIFT_LO, SHIFT_HI, GAP, LATCH} state_t;

    state_t        state, state_next;
    logic [TW-1:0] tick, tick_next;
    logic [4:0]    bit_idx, bit_next;
    logic [2:0]    lane, lane_next;
    logic [23:0]   data, data_next;
    logic          bad_cmd, bad_next;
    logic          overrun, over_next;

    logic [2:0]    cmd_lane;
    logic [4:0]    cmd_bits;
    logic [23:0]   cmd_data;
    logic          cmd_ok;
    logic          tick_done;

    logic [CHANNEL_COUNT-1:0] sel, clk_d, sdi_d, le_d;

    assign cmd_lane  = sysGPIO_OUT[31:29];
    assign cmd_bits  = sysGPIO_OUT[28:24];
    assign cmd_data  = sysGPIO_OUT[23:0];
    assign cmd_ok    = (cmd_bits != 5'd0) && (int'(cmd_bits) <= DATA_WIDTH) &&
                       ((int'(cmd_lane) < CHANNEL_COUNT) || (BROADCAST && cmd_lane == 3'd7));
    assign tick_done = (tick == '0);

    assign status = {(state != IDLE), bad_cmd, overrun, lane, 2'b00, data};

    always_ff @(posedge sysClk) begin
        if (sysReset) begin
            state       <= IDLE;
            tick        <= '0;
            bit_idx     <= '0;
            lane        <= '0;
            data        <= '0;
            bad_cmd     <= 1'b0;
            overrun     <= 1'b0;
            AFE_SPI_CLK <= '0;
            AFE_SPI_SDI <= '0;
            AFE_SPI_LE  <= '0;
        end else begin
            state       <= state_next;
            tick        <= tick_next;
            bit_idx     <= bit_next;
            lane        <= lane_next;
            data        <= data_next;
            bad_cmd     <= bad_next;
            overrun     <= over_next;
            AFE_SPI_CLK <= clk_d;
            AFE_SPI_SDI <= sdi_d;
            AFE_SPI_LE  <= le_d;
        end
    end

    always_comb begin
        state_next = state;
        tick_next  = tick;
        bit_next   = bit_idx;
        lane_next  = lane;
        data_next  = data;
        bad_next   = bad_cmd;
        over_next  = overrun;
        case (state)
            IDLE: begin
                if (sysCsrStrobe) begin
                    if (cmd_ok) begin
                        state_next = SHIFT_LO;
                        tick_next  = PHASE_RELOAD;
                        bit_next   = cmd_bits - 5'd1;
                        lane_next  = cmd_lane;
                        data_next  = cmd_data;
                        bad_next   = 1'b0;
                        over_next  = 1'b0;
                    end else begin
                        bad_next   = 1'b1;
                    end
                end
            end
            SHIFT_LO: begin
                if (tick_done) begin
                    state_next = SHIFT_HI;
                    tick_next  = PHASE_RELOAD;
                end else begin
                    tick_next  = tick - TW'(1);
                end
            end
            SHIFT_HI: begin
                if (tick_done) begin
                    tick_next = PHASE_RELOAD;
                    if (bit_idx == 5'd0) begin
                        state_next = GAP;
                    end else begin
                        state_next = SHIFT_LO;
                        bit_next   = bit_idx - 5'd1;
                    end
                end else begin
                    tick_next = tick - TW'(1);
                end
            end
            GAP: begin
                if (tick_done) begin
                    state_next = LATCH;
                    tick_next  = LATCH_RELOAD;
                end else begin
                    tick_next  = tick - TW'(1);
                end
            end
            LATCH: begin
                if (tick_done) begin
                    state_next = IDLE;
                end else begin
                    tick_next  = tick - TW'(1);
                end
            end
            default: state_next = IDLE;
        endcase
        // Any strobe outside IDLE, including the final LATCH cycle, is an overrun.
        if (sysCsrStrobe && state != IDLE) begin
            over_next = 1'b1;
        end
    end

    // Pins are decoded from the next state and registered so they never glitch.
    always_comb begin
        sel   = '0;
        clk_d = '0;
        sdi_d = '0;
        le_d  = '0;
        for (int i = 0; i < CHANNEL_COUNT; i++) begin
            sel[i] = (BROADCAST && lane_next == 3'd7) || (lane_next == 3'(i));
        end
        case (state_next)
            SHIFT_LO: sdi_d = data_next[bit_next] ? sel : '0;
            SHIFT_HI: begin
                clk_d = sel;
                sdi_d = data_next[bit_next] ? sel : '0;
            end
            LATCH:    le_d  = sel;
            default:  ;
        endcase
    end

endmodule

// File: tb/tb_afe_spi_shifter.sv
// Self-checking bench for afe_spi_shifter: cycle-accurate waveform model plus directed literal checks.
// Honours AFE_SPI_BROADCAST_EN the same way the design does.
module tb_afe_spi_shifter;

`ifdef AFE_SPI_BROADCAST_EN
    localparam bit BC = 1'b1;
`else
    localparam bit BC = 1'b0;
`endif

    localparam int D   = 5;
    localparam int LEH = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        strobe;
    logic [31:0] gpio;
    logic [31:0] status;
    logic [1:0]  spi_clk, spi_sdi, spi_le;

    int checks = 0;
    int errors = 0;

    afe_spi_shifter #(
        .CLK_RATE(100), .SPI_RATE(10), .CHANNEL_COUNT(2), .DATA_WIDTH(24), .LE_HALF_PERIODS(LEH)
    ) dut (
        .sysClk(clk), .sysReset(reset), .sysCsrStrobe(strobe), .sysGPIO_OUT(gpio),
        .status(status), .AFE_SPI_CLK(spi_clk), .AFE_SPI_SDI(spi_sdi), .AFE_SPI_LE(spi_le)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit cmd_valid(input logic [31:0] w);
        int n;
        n = int'(w[28:24]);
        return (n >= 1) && (n <= 24) && ((w[31:29] < 3'd2) || (BC && w[31:29] == 3'd7));
    endfunction

    // Model: a transfer is a timeline indexed by cycles since acceptance.
    bit          m_active = 0, m_bad = 0, m_over = 0;
    int          m_k = 0, m_n = 0;
    logic [2:0]  m_lane = 0;
    logic [23:0] m_data = 0;

    always @(posedge clk) begin
        bit busy_pre;
        if (reset) begin
            m_active = 0; m_bad = 0; m_over = 0; m_k = 0; m_n = 0; m_lane = 0; m_data = 0;
        end else begin
            busy_pre = m_active;
            if (m_active) begin
                m_k++;
                if (m_k == (2 * m_n + 1 + LEH) * D) m_active = 0;
            end
            if (strobe) begin
                if (busy_pre) m_over = 1;
                else if (cmd_valid(gpio)) begin
                    m_active = 1; m_k = 0; m_lane = gpio[31:29]; m_n = int'(gpio[28:24]);
                    m_data = gpio[23:0]; m_bad = 0; m_over = 0;
                end else m_bad = 1;
            end
        end
    end

    int          rise_cnt [2] = '{0, 0};
    int          le_cnt   [2] = '{0, 0};
    int          sdi_cnt  [2] = '{0, 0};
    logic [31:0] rise_bits[2] = '{0, 0};
    int          busy_cnt = 0;
    logic [1:0]  prev_clk = 2'b00;

    always @(negedge clk) begin
        logic [1:0] sel, e_clk, e_sdi, e_le;
        int bitn;
        sel = (m_lane == 3'd7) ? 2'b11 : (2'b01 << m_lane);
        e_clk = 0; e_sdi = 0; e_le = 0;
        if (m_active) begin
            if (m_k < 2 * m_n * D) begin
                bitn = m_k / (2 * D);
                if ((m_k / D) % 2 == 1) e_clk = sel;
                if (m_data[m_n - 1 - bitn]) e_sdi = sel;
            end else if (m_k >= (2 * m_n + 1) * D) begin
                e_le = sel;
            end
        end
        check_output("pin_clk", 32'(spi_clk), 32'(e_clk));
        check_output("pin_sdi", 32'(spi_sdi), 32'(e_sdi));
        check_output("pin_le", 32'(spi_le), 32'(e_le));
        check_output("status", status, {m_active, m_bad, m_over, m_lane, 2'b00, m_data});
        for (int i = 0; i < 2; i++) begin
            if (spi_clk[i] && !prev_clk[i]) begin
                rise_cnt[i]++;
                rise_bits[i] = {rise_bits[i][30:0], spi_sdi[i]};
            end
            le_cnt[i]  += int'(spi_le[i]);
            sdi_cnt[i] += int'(spi_sdi[i]);
        end
        busy_cnt += int'(status[31]);
        prev_clk = spi_clk;
    end

    int b_rise[2], b_le[2], b_sdi[2], b_busy;

    task automatic snapshot();
        for (int i = 0; i < 2; i++) begin
            b_rise[i] = rise_cnt[i]; b_le[i] = le_cnt[i]; b_sdi[i] = sdi_cnt[i];
        end
        b_busy = busy_cnt;
    endtask

    function automatic int activity(input int i);
        return (rise_cnt[i] - b_rise[i]) + (le_cnt[i] - b_le[i]) + (sdi_cnt[i] - b_sdi[i]);
    endfunction

    task automatic apply_stimulus(input logic [2:0] lane, input logic [4:0] n, input logic [23:0] d);
        @(posedge clk); #1;
        strobe = 1'b1; gpio = {lane, n, d};
        @(posedge clk); #1;
        strobe = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        @(negedge clk);
        while (status[31] && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_output("idle_timeout", 32'(status[31]), 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        reset = 1'b1; strobe = 1'b0; gpio = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_output("reset_status", status, 32'h0);
        check_output("reset_pins", 32'({spi_le, spi_sdi, spi_clk}), 32'h0);

        $display("[TB] lane0 N=8 0xA5");
        snapshot();
        apply_stimulus(3'd0, 5'd8, 24'hA5);
        wait_idle(300);
        check_output("t1_rises0", 32'(rise_cnt[0] - b_rise[0]), 32'd8);
        check_output("t1_bits0", 32'(rise_bits[0][7:0]), 32'hA5);
        check_output("t1_le0", 32'(le_cnt[0] - b_le[0]), 32'd10);
        check_output("t1_busy", 32'(busy_cnt - b_busy), 32'd95);
        check_output("t1_lane1_quiet", 32'(activity(1)), 32'd0);
        check_output("t1_status", status, 32'h000000A5);

        $display("[TB] lane1 N=24 with overrun");
        snapshot();
        apply_stimulus(3'd1, 5'd24, 24'hFFFFFF);
        repeat (20) @(posedge clk);
        apply_stimulus(3'd0, 5'd8, 24'h11);
        wait_idle(1000);
        check_output("t2_rises1", 32'(rise_cnt[1] - b_rise[1]), 32'd24);
        check_output("t2_bits1", 32'(rise_bits[1][23:0]), 32'hFFFFFF);
        check_output("t2_le1", 32'(le_cnt[1] - b_le[1]), 32'd10);
        check_output("t2_lane0_quiet", 32'(activity(0)), 32'd0);
        check_output("t2_busy", 32'(busy_cnt - b_busy), 32'd255);
        check_output("t2_status", status, 32'h24FFFFFF);

        $display("[TB] back-to-back in first idle cycle");
        snapshot();
        strobe = 1'b1; gpio = {3'd0, 5'd4, 24'h9};
        @(posedge clk); #1 strobe = 1'b0;
        @(negedge clk);
        check_output("t3_b2b_busy", 32'(status[31]), 32'd1);
        check_output("t3_b2b_overrun", 32'(status[29]), 32'd0);
        wait_idle(300);
        check_output("t3_rises0", 32'(rise_cnt[0] - b_rise[0]), 32'd4);
        check_output("t3_bits0", 32'(rise_bits[0][3:0]), 32'h9);
        check_output("t3_status", status, 32'h00000009);

        $display("[TB] strobe on last busy cycle");
        snapshot();
        apply_stimulus(3'd1, 5'd2, 24'h3);
        repeat (34) @(posedge clk);
        #1 strobe = 1'b1; gpio = {3'd0, 5'd4, 24'h5};
        @(posedge clk); #1 strobe = 1'b0;
        @(negedge clk);
        check_output("t4_status", status, 32'h24000003);
        check_output("t4_busy", 32'(busy_cnt - b_busy), 32'd35);
        check_output("t4_bits1", 32'(rise_bits[1][1:0]), 32'h3);

        $display("[TB] rejected commands");
        snapshot();
        apply_stimulus(3'd0, 5'd0, 24'h1);
        @(negedge clk);
        check_output("t5_n0", 32'(status[31:30]), 32'h1);
        apply_stimulus(3'd1, 5'd25, 24'h1);
        @(negedge clk);
        check_output("t5_n25", 32'(status[31:30]), 32'h1);
        apply_stimulus(3'd3, 5'd4, 24'h1);
        @(negedge clk);
        check_output("t5_lane3", 32'(status[31:30]), 32'h1);
        repeat (5) @(negedge clk);
        check_output("t5_quiet", 32'(activity(0) + activity(1) + busy_cnt - b_busy), 32'd0);
        check_output("t5_last_kept", {status[28:26], status[23:0]}, {5'd0, 3'd1, 24'h3});

        $display("[TB] reset mid-transfer");
        snapshot();
        apply_stimulus(3'd0, 5'd16, 24'hABCD);
        repeat (42) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check_output("t6_pins", 32'({spi_le, spi_sdi, spi_clk}), 32'h0);
        check_output("t6_status", status, 32'h0);
        repeat (150) @(negedge clk);
        check_output("t6_no_le", 32'(le_cnt[0] - b_le[0]), 32'd0);
        snapshot();
        apply_stimulus(3'd0, 5'd4, 24'h9);
        wait_idle(300);
        check_output("t6_rises0", 32'(rise_cnt[0] - b_rise[0]), 32'd4);
        check_output("t6_bits0", 32'(rise_bits[0][3:0]), 32'h9);

        $display("[TB] lane code 7");
        snapshot();
        apply_stimulus(3'd7, 5'd6, 24'h2B);
        wait_idle(300);
        if (BC) begin
            check_output("t7_rises0", 32'(rise_cnt[0] - b_rise[0]), 32'd6);
            check_output("t7_rises1", 32'(rise_cnt[1] - b_rise[1]), 32'd6);
            check_output("t7_bits0", 32'(rise_bits[0][5:0]), 32'h2B);
            check_output("t7_bits1", 32'(rise_bits[1][5:0]), 32'h2B);
            check_output("t7_le", 32'(le_cnt[0] - b_le[0] + le_cnt[1] - b_le[1]), 32'd20);
            check_output("t7_status", status, 32'h1C00002B);
        end else begin
            check_output("t7_quiet", 32'(activity(0) + activity(1)), 32'd0);
            check_output("t7_status", status, 32'h40000009);
        end

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
